temp_seg_display: RTL and testbench



---
 rtl/temp_seg_display.sv | 160 ++++++++++++++++
 tb/tb_temp_seg_display.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/temp_seg_display.sv
// Samples a binary temperature, clamps it to 9999, converts it to BCD with a serial
// double-dabble FSM and scans it onto a 4-digit active-low 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros in the upper three digits.
module temp_seg_display #(
   parameter int REFRESH_DIV = 100000,
   parameter int UPDATE_DIV  = 25000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] temp_in,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        busy,
   output logic        bcd_valid
);

   localparam int UPD_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
   localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [UPD_W-1:0] UPD_MAX = UPD_W'(UPDATE_DIV - 1);
   localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q;
   logic [UPD_W-1:0] upd_cnt_q, upd_cnt_d;
   logic [REF_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [1:0]       scan_idx_q, scan_idx_d;
   logic             upd_tick, scan_wrap;
   logic [13:0]      bin_q;
   logic [15:0]      bcd_q, bcd_adj;
   logic [3:0]       iter_q;
   logic [15:0]      disp_q;
   logic             busy_q, valid_q;
   logic [6:0]       seg_q, seg_d;
   logic [3:0]       an_q, an_d;
   logic [3:0]       blank;
   logic [3:0]       digit;
   logic [13:0]      bin_clamped;

   function automatic logic [6:0] seg_enc(input logic [3:0] d);
      case (d)
         4'd0:    seg_enc = 7'b1000000;
         4'd1:    seg_enc = 7'b1111001;
         4'd2:    seg_enc = 7'b0100100;
         4'd3:    seg_enc = 7'b0110000;
         4'd4:    seg_enc = 7'b0011001;
         4'd5:    seg_enc = 7'b0010010;
         4'd6:    seg_enc = 7'b0000010;
         4'd7:    seg_enc = 7'b1111000;
         4'd8:    seg_enc = 7'b0000000;
         4'd9:    seg_enc = 7'b0010000;
         default: seg_enc = 7'b1111111;
      endcase
   endfunction

   always_comb begin
      upd_tick  = (upd_cnt_q == UPD_MAX);
      upd_cnt_d = upd_tick ? '0 : upd_cnt_q + 1'b1;
      scan_wrap  = (scan_cnt_q == REF_MAX);
      scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
      scan_idx_d = scan_wrap ? scan_idx_q + 2'd1 : scan_idx_q;
      bin_clamped = (temp_in > 16'd9999) ? 14'd9999 : temp_in[13:0];
   end

   // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 4; i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5)
            bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         upd_cnt_q  <= '0;
         scan_cnt_q <= '0;
         scan_idx_q <= 2'd0;
      end else begin
         upd_cnt_q  <= upd_cnt_d;
         scan_cnt_q <= scan_cnt_d;
         scan_idx_q <= scan_idx_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         iter_q  <= '0;
         disp_q  <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (upd_tick) begin
                  bin_q   <= bin_clamped;
                  bcd_q   <= '0;
                  iter_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               bcd_q  <= {bcd_adj[14:0], bin_q[13]};
               bin_q  <= {bin_q[12:0], 1'b0};
               iter_q <= iter_q + 4'd1;
               if (iter_q == 4'd13)
                  state_q <= DONE;
            end
            DONE: begin
               disp_q  <= bcd_q;
               valid_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      blank = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
      blank[3] = (disp_q[15:12] == 4'd0);
      blank[2] = blank[3] && (disp_q[11:8] == 4'd0);
      blank[1] = blank[2] && (disp_q[7:4] == 4'd0);
`endif
      case (scan_idx_q)
         2'd0:    digit = disp_q[3:0];
         2'd1:    digit = disp_q[7:4];
         2'd2:    digit = disp_q[11:8];
         default: digit = disp_q[15:12];
      endcase
      seg_d = blank[scan_idx_q] ? 7'b1111111 : seg_enc(digit);
      an_d  = ~(4'b0001 << scan_idx_q);
   end

   // seg and an share one register stage so a digit change never ghosts.
   always_ff @(posedge clk) begin
      if (reset) begin
         seg_q <= 7'h7F;
         an_q  <= 4'hF;
      end else begin
         seg_q <= seg_d;
         an_q  <= an_d;
      end
   end

   assign seg       = seg_q;
   assign an        = an_q;
   assign dp        = 1'b1;
   assign busy      = busy_q;
   assign bcd_valid = valid_q;

endmodule

// File: tb/tb_temp_seg_display.sv
// Self-checking bench for temp_seg_display with short dividers; expected digits are
// computed from the decimal value with plain arithmetic.
module tb_temp_seg_display;

   localparam int REF = 4;
   localparam int UPD = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] temp_in = '0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        busy;
   logic        bcd_valid;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc;
   logic [15:0] exp_q[$];

   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
   int pw [4] = '{1, 10, 100, 1000};

   temp_seg_display #(.REFRESH_DIV(REF), .UPDATE_DIV(UPD)) dut (
      .clk(clk), .reset(reset), .temp_in(temp_in), .seg(seg), .dp(dp),
      .an(an), .busy(busy), .bcd_valid(bcd_valid)
   );

   always #5 clk = ~clk;

   // Cycles since reset release; the update divider is at cyc % UPD.
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   function automatic int clamp(input int v);
      return (v > 9999) ? 9999 : v;
   endfunction

   function automatic logic [6:0] exp_seg(input int val, input int slot);
      int v;
      v = clamp(val);
`ifdef LEADING_ZERO_BLANK_EN
      if (slot > 0 && v < pw[slot]) return 7'b1111111;
`endif
      return seg_tab[(v / pw[slot]) % 10];
   endfunction

   task automatic check_display(input int val);
      int slot;
      for (int i = 0; i < 4*REF + 4; i++) begin
         @(negedge clk);
         case (an)
            4'b1110: slot = 0;
            4'b1101: slot = 1;
            4'b1011: slot = 2;
            4'b0111: slot = 3;
            default: slot = -1;
         endcase
         n_checks++;
         if (slot < 0 || dp !== 1'b1)
            $display("FAIL display_anode val=%0d an=%b dp=%b", val, an, dp);
         else if (seg !== exp_seg(val, slot))
            $display("FAIL display_seg val=%0d slot=%0d seg=%b expected=%b", val, slot, seg, exp_seg(val, slot));
         else
            n_pass++;
      end
   endtask

   task automatic do_conversion(input int v, input int change_at, input int v2);
      int guard;
      logic [15:0] got;
      temp_in = 16'(v);
      guard = 0;
      while ((cyc % UPD) != UPD - 1 && guard < 2*UPD) begin
         @(negedge clk);
         guard++;
      end
      n_checks++;
      if (guard >= 2*UPD || busy !== 1'b0) begin
         $display("FAIL wait_tick guard=%0d busy=%b expected busy=0", guard, busy);
         return;
      end
      n_pass++;
      exp_q.push_back(16'(clamp(v)));
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         if (k == change_at) temp_in = 16'(v2);
         if (k == 1) begin
            n_checks++;
            if (busy !== 1'b1) $display("FAIL busy_start busy=%b expected=1", busy);
            else n_pass++;
         end
         if (k == 15) begin
            n_checks++;
            if (bcd_valid !== 1'b0 || busy !== 1'b1)
               $display("FAIL pre_valid bcd_valid=%b busy=%b expected 0/1", bcd_valid, busy);
            else n_pass++;
         end
         if (k == 16) begin
            n_checks++;
            if (bcd_valid !== 1'b1 || busy !== 1'b0)
               $display("FAIL valid_latency bcd_valid=%b busy=%b expected 1/0", bcd_valid, busy);
            else n_pass++;
         end
         if (k == 17) begin
            n_checks++;
            if (bcd_valid !== 1'b0) $display("FAIL valid_pulse_width bcd_valid=%b expected=0", bcd_valid);
            else n_pass++;
         end
      end
      got = exp_q.pop_front();
      check_display(int'(got));
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || busy !== 1'b0 || bcd_valid !== 1'b0)
         $display("FAIL reset_values an=%h seg=%h dp=%b busy=%b valid=%b expected F/7F/1/0/0",
                  an, seg, dp, busy, bcd_valid);
      else n_pass++;
   endtask

   task automatic test_scan_timing();
      logic [3:0] exp_an;
      reset = 1'b0;
      for (int i = 1; i <= 5*REF; i++) begin
         @(negedge clk);
         exp_an = ~(4'b0001 << (((i - 1) / REF) % 4));
         n_checks++;
         if (an !== exp_an || dp !== 1'b1)
            $display("FAIL scan_timing cycle=%0d an=%b dp=%b expected an=%b dp=1", i, an, dp, exp_an);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      int guard;
      int seen;
      temp_in = 16'd4321;
      guard = 0;
      while ((cyc % UPD) != UPD - 1 && guard < 2*UPD) begin
         @(negedge clk);
         guard++;
      end
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (an !== 4'hF || seg !== 7'h7F || busy !== 1'b0 || bcd_valid !== 1'b0)
         $display("FAIL reset_mid an=%h seg=%h busy=%b valid=%b expected F/7F/0/0", an, seg, busy, bcd_valid);
      else n_pass++;
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bcd_valid !== 1'b0 || busy !== 1'b0) seen++;
      end
      n_checks++;
      if (seen != 0) $display("FAIL reset_mid_discard active_cycles=%0d expected=0", seen);
      else n_pass++;
      check_display(0);
      do_conversion(4321, 0, 0);
   endtask

   task automatic test_random();
      int v;
      for (int n = 0; n < 8; n++) begin
         case (n % 3)
            0:       v = int'($urandom_range(0, 65535));
            1:       v = int'($urandom_range(0, 9999));
            default: v = int'($urandom_range(0, 99));
         endcase
         do_conversion(v, int'($urandom_range(1, 15)), int'($urandom_range(0, 65535)));
      end
   endtask

   initial begin
      test_reset();
      test_scan_timing();
      do_conversion(25, 0, 0);       // basic value
      do_conversion(12345, 0, 0);    // clamp to 9999
      do_conversion(1234, 3, 5678);  // input change during SHIFT ignored
      do_conversion(5678, 0, 0);
      do_conversion(7, 0, 0);        // leading-zero behaviour
      do_conversion(0, 0, 0);
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
